// File: rtl/instr_pkg.sv
// Shared MIPS instruction field definitions, common to the field parser and the encoder/loader.
// Holds the format and state enums, opcode constants, field bit positions and the word packer.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int ADDR_LSB   = 0;

  // The reserved format packs like an I-type; callers that care must reject it first.
  function automatic logic [31:0] pack_fields(
    input logic [1:0]  fmt,
    input logic [5:0]  opcode,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] immediate,
    input logic [25:0] address
  );
    logic [31:0] w;
    case (fmt_e'(fmt))
      FMT_R: w = (32'(OP_RTYPE) << OPCODE_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
               | (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
      FMT_J: w = (32'(opcode) << OPCODE_LSB) | (32'(address) << ADDR_LSB);
      default: w = (32'(opcode) << OPCODE_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                 | (32'(immediate) << IMM_LSB);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO between the word packer and the imem write port; zero-latency head read.
// Push while full is honoured only when a pop happens in the same cycle.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS fields into words and streams them to imem at sequential addresses; 1-cycle accept-to-write latency.
// in_ready drops when the buffer or session is full; ENC_FIELD_CHECK_EN enables opcode/format rejection with sticky err.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH      = 256,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        finish,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] address,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [15:0] word_count,
  output logic        full,
  output logic        busy,
  output logic        err
);

  state_e      state;
  logic [31:0] push_addr;
  logic [31:0] word;
  logic [63:0] head;
  logic        fifo_empty, fifo_full;
  logic        field_bad, accept, push, pop, begin_load;

  assign word = pack_fields(fmt, opcode, rs, rt, rd, shamt, funct, immediate, address);

`ifdef ENC_FIELD_CHECK_EN
  always_comb begin
    field_bad = 1'b0;
    case (fmt_e'(fmt))
      FMT_R:   field_bad = (opcode != OP_RTYPE);
      FMT_I:   field_bad = (opcode == OP_RTYPE) || (opcode == OP_J) || (opcode == OP_JAL);
      FMT_J:   field_bad = !((opcode == OP_J) || (opcode == OP_JAL));
      default: field_bad = 1'b1;
    endcase
  end
`else
  assign field_bad = 1'b0;
`endif

  // in_ready depends only on registered state, so wr_ready never reaches it combinationally.
  assign in_ready   = (state == ST_LOAD) && !fifo_full && !full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && !field_bad;
  assign pop        = wr_valid && wr_ready;
  assign begin_load = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign full     = (word_count == 16'(DEPTH));
  assign busy     = (state == ST_LOAD) || (state == ST_DRAIN);
  assign wr_valid = !fifo_empty;
  // With the buffer empty, the next push address is also the next write address.
  assign wr_addr  = fifo_empty ? push_addr : head[63:32];
  assign wr_data  = fifo_empty ? 32'h0 : head[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      push_addr  <= BASE_ADDR;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            push_addr  <= BASE_ADDR;
            word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (push) begin
            push_addr  <= push_addr + 32'd4;
            word_count <= word_count + 16'd1;
          end
          if (finish || full) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENC_FIELD_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_q <= 1'b0;
    else if (begin_load)         err_q <= 1'b0;
    else if (accept && field_bad) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({push_addr, word}),
    .pop      (pop),
    .pop_dat  (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule
